// File: rtl/seq_divider_pkg.sv
// Shared widths and FSM encoding for the sequential restoring divider.
package seq_divider_pkg;

    localparam int NW_DEF = 16;
    localparam int DW_DEF = 8;
    localparam int CNT_W  = $clog2(NW_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/done request and result bundle between a requester (master) and the divider (slave).
interface seq_divider_if #(
    parameter int NW = seq_divider_pkg::NW_DEF,
    parameter int DW = seq_divider_pkg::DW_DEF
);
    logic          start;
    logic [NW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          ready;
    logic          done;
    logic [NW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int DW = 8
) (
    input  logic [DW:0]   r,
    input  logic [DW-1:0] d,
    input  logic          msb_in,
    output logic [DW:0]   r_next,
    output logic          q_bit
);
    logic [DW:0] r_shift;
    logic [DW:0] trial;

    // The extra top bit of r acts as the borrow flag of the trial subtraction.
    assign r_shift = {r[DW-1:0], msb_in};
    assign trial   = r_shift - {1'b0, d};
    assign q_bit   = ~trial[DW];
    assign r_next  = q_bit ? trial : r_shift;
endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
// Results are registered on entry to DONE and held until the next completion.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int NW = NW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(NW - 1);

    state_t        state, state_nx;
    logic [NW-1:0] q_reg, q_nx;
    logic [DW-1:0] d_reg, d_nx;
    logic [DW:0]   r_reg, r_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [NW-1:0] quot, quot_nx;
    logic [DW-1:0] rem, rem_nx;
    logic          dz, dz_nx;

    logic [DW:0]   step_r;
    logic          step_q;

    div_step #(.DW(DW)) u_step (
        .r      (r_reg),
        .d      (d_reg),
        .msb_in (q_reg[NW-1]),
        .r_next (step_r),
        .q_bit  (step_q)
    );

    always_comb begin
        state_nx = state;
        q_nx     = q_reg;
        d_nx     = d_reg;
        r_nx     = r_reg;
        cnt_nx   = cnt;
        quot_nx  = quot;
        rem_nx   = rem;
        dz_nx    = dz;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        state_nx = RUN;
                        q_nx     = bus.dividend;
                        d_nx     = bus.divisor;
                        r_nx     = '0;
                        cnt_nx   = '0;
                    end else begin
                        // Divide by zero skips the iteration entirely.
                        state_nx = DONE;
                        quot_nx  = '1;
                        rem_nx   = bus.dividend[DW-1:0];
                        dz_nx    = 1'b1;
                    end
                end
            end
            RUN: begin
                q_nx   = {q_reg[NW-2:0], step_q};
                r_nx   = step_r;
                cnt_nx = cnt + CW'(1);
                if (cnt == LAST_STEP) begin
                    state_nx = DONE;
                    quot_nx  = {q_reg[NW-2:0], step_q};
                    rem_nx   = step_r[DW-1:0];
                    dz_nx    = 1'b0;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            q_reg <= '0;
            d_reg <= '0;
            r_reg <= '0;
            cnt   <= '0;
            quot  <= '0;
            rem   <= '0;
            dz    <= 1'b0;
        end else begin
            state <= state_nx;
            q_reg <= q_nx;
            d_reg <= d_nx;
            r_reg <= r_nx;
            cnt   <= cnt_nx;
            quot  <= quot_nx;
            rem   <= rem_nx;
            dz    <= dz_nx;
        end
    end

    assign bus.ready       = (state == IDLE);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quot;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dz;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a negedge monitor checks them.
module tb_seq_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_divider_if #(.NW(16), .DW(8)) bus();

    seq_divider #(.NW(16), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] n;
        logic [7:0]  d;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          acc;
        int          lat_min;
        int          lat_max;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   gap_base = 0;
    int   lat = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending request (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient", 32'(bus.quotient), 32'(mon_e.q));
                chk("remainder", 32'(bus.remainder), 32'(mon_e.r));
                chk("div_by_zero", 32'(bus.div_by_zero), 32'(mon_e.dz));
                lat = cyc - mon_e.acc;
                n_cmp++;
                if (lat < mon_e.lat_min || lat > mon_e.lat_max) begin
                    n_bad++;
                    $display("FAIL latency: got %0d expected %0d..%0d", lat, mon_e.lat_min, mon_e.lat_max);
                end
                if (mon_e.d != 8'd0) begin
                    chk("identity", 32'(bus.quotient) * 32'(mon_e.d) + 32'(bus.remainder), 32'(mon_e.n));
                    chk("rem_lt_div", 32'(bus.remainder < mon_e.d), 32'd1);
                end
            end
        end
    end

    // Called at a negedge; waits (bounded) for ready, then presents one request for one cycle.
    task automatic issue(input logic [15:0] n, input logic [7:0] d);
        int   w;
        exp_t e;
        w = 0;
        while (bus.ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (bus.ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got ready=%b expected 1 within 100 cycles", bus.ready);
            return;
        end
        bus.start    = 1'b1;
        bus.dividend = n;
        bus.divisor  = d;
        e.n   = n;
        e.d   = d;
        e.q   = (d != 8'd0) ? n / 16'(d) : 16'hFFFF;
        e.r   = (d != 8'd0) ? 8'(n % 16'(d)) : n[7:0];
        e.dz  = (d == 8'd0);
        e.acc = cyc + 1;
        e.lat_min = (d != 8'd0) ? 16 : 0;
        e.lat_max = (d != 8'd0) ? 16 : 1;
        last_acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = n ^ 16'h5A5A;
        bus.divisor  = d ^ 8'hA5;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_quotient", 32'(bus.quotient), 32'd0);
        chk("rst_remainder", 32'(bus.remainder), 32'd0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(16'd50000, 8'd7);
        drain();

        // Reset in the middle of an operation: outputs clear and no done follows.
        bus.start    = 1'b1;
        bus.dividend = 16'hFFFF;
        bus.divisor  = 8'h03;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrun_busy", 32'(bus.ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_ready", 32'(bus.ready), 32'd1);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_quotient", 32'(bus.quotient), 32'd0);
        chk("abort_remainder", 32'(bus.remainder), 32'd0);
        chk("abort_dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);

        issue(16'hFFFF, 8'h01);
        issue(16'd5, 8'd9);
        drain();

        issue(16'h1234, 8'd0);
        gap_base = last_acc;
        issue(16'd100, 8'd10);
        chk("dbz_next_accept_gap", 32'(last_acc - gap_base), 32'd2);
        drain();

        // Starts while busy must be ignored; the next start on the first ready cycle is taken.
        issue(16'd1000, 8'd3);
        gap_base = last_acc;
        repeat (3) begin
            chk("busy_ready", 32'(bus.ready), 32'd0);
            bus.start    = 1'b1;
            bus.dividend = 16'h0BAD;
            bus.divisor  = 8'd2;
            @(negedge clk);
        end
        bus.start = 1'b0;
        issue(16'd255, 8'd16);
        chk("b2b_accept_gap", 32'(last_acc - gap_base), 32'd18);
        drain();

        for (int a = 0; a < 256; a += 17) begin
            for (int b = 1; b < 256; b += 23) begin
                issue(16'(a * b), 8'(b));
            end
        end
        drain();

        for (int i = 0; i < 1500; i++) begin
            issue(16'($urandom_range(0, 65535)), 8'($urandom_range(1, 255)));
        end
        drain();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
